// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter placing N_MASTER requesters onto one TCDM bank, with zero-cycle grant.
// Define TCDM_ARB_OUTREG_EN to add one response register stage (latency 2 instead of 1).
module tcdm_bank_arbiter #(
    parameter int unsigned N_MASTER   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_MASTER-1:0]                   req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]   add_i,
    input  logic [N_MASTER-1:0]                   wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]   wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]     be_i,
    output logic [N_MASTER-1:0]                   gnt_o,
    output logic [N_MASTER-1:0]                   r_valid_o,
    output logic [DATA_WIDTH-1:0]                 r_rdata_o,
    output logic                                  mem_req_o,
    output logic [ADDR_WIDTH-1:0]                 mem_add_o,
    output logic                                  mem_wen_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    output logic [BE_WIDTH-1:0]                   mem_be_o,
    input  logic                                  mem_gnt_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i
);

    localparam int unsigned PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    w;
    logic [PTR_W-1:0]    ptr_next;
    logic                accept;
    logic [N_MASTER-1:0] w_onehot;
    logic [N_MASTER-1:0] r_id;

    // Winner: lowest requesting index >= ptr, else lowest requesting index below ptr (wrap).
    always_comb begin
        w = '0;
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (req_i[i] && (i < int'(ptr))) w = PTR_W'(i);
        end
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (req_i[i] && (i >= int'(ptr))) w = PTR_W'(i);
        end
    end

    assign mem_req_o = |req_i;
    assign accept    = mem_req_o & mem_gnt_i;
    assign w_onehot  = N_MASTER'(1) << w;
    assign gnt_o     = accept ? w_onehot : '0;
    assign ptr_next  = (int'(w) == int'(N_MASTER) - 1) ? '0 : w + PTR_W'(1);

    always_comb begin
        mem_add_o   = '0;
        mem_wen_o   = 1'b1;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (mem_req_o) begin
            mem_add_o   = add_i[w];
            mem_wen_o   = wen_i[w];
            mem_wdata_o = wdata_i[w];
            mem_be_o    = be_i[w];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= '0;
            r_id <= '0;
        end else begin
            if (accept) ptr <= ptr_next;
            r_id <= accept ? w_onehot : '0;
        end
    end

`ifdef TCDM_ARB_OUTREG_EN
    // Extra response stage: bank data is captured the cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_o <= '0;
            r_rdata_o <= '0;
        end else begin
            r_valid_o <= r_id;
            r_rdata_o <= mem_rdata_i;
        end
    end
`else
    assign r_valid_o = r_id;
    assign r_rdata_o = mem_rdata_i;
`endif

endmodule
